pipemem_arb: RTL and testbench

//  Arbiter for the single-port unified memory shared by the IF stage (instruction

---
 rtl/pipemem_arb.sv | 151 +++++++++++++++
 tb/tb_pipemem_arb.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipemem_arb.sv
// Single-port memory arbiter between the IF and MEM pipeline stages. Each access
// runs IDLE -> BUSY -> DONE. Optional MEMARB_PERF_EN macro adds saturating perf counters.
module pipemem_arb #(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          m_req,
  input  logic          m_we,
  input  logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_wdata,
  output logic [DW-1:0] m_rdata,
  output logic          m_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef MEMARB_PERF_EN
  ,
  output logic [31:0]   perf_ifetch,
  output logic [31:0]   perf_dacc,
  output logic [31:0]   perf_confl
`endif
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [3:0] LoadCnt = 4'(WAIT_CYCLES - 1);

  state_e        r_state;
  state_e        w_state_d;
  logic          r_last_gnt_data;
  logic          r_gnt_data;
  logic          r_we;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_m_rdata;
  logic          w_any_req;
  logic          w_gnt_data;

  assign w_any_req = if_req | m_req;
  // Data wins unless it also took the previous grant and a fetch is waiting.
  assign w_gnt_data = m_req & ~(r_last_gnt_data & if_req);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    if_ack    = 1'b0;
    m_ack     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_any_req) w_state_d = StBusy;
      end
      StBusy: begin
        mem_en = 1'b1;
        mem_we = r_gnt_data & r_we;
        if (r_cnt == 4'd0) w_state_d = StDone;
      end
      StDone: begin
        if_ack    = ~r_gnt_data;
        m_ack     = r_gnt_data;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_last_gnt_data <= 1'b1;
      r_gnt_data      <= 1'b0;
      r_we            <= 1'b0;
      r_cnt           <= 4'd0;
      r_mem_addr      <= '0;
      r_mem_wdata     <= '0;
      r_if_rdata      <= '0;
      r_m_rdata       <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_gnt_data      <= w_gnt_data;
            r_last_gnt_data <= w_gnt_data;
            r_we            <= w_gnt_data & m_we;
            r_mem_addr      <= w_gnt_data ? m_addr : if_addr;
            r_mem_wdata     <= w_gnt_data ? m_wdata : '0;
            r_cnt           <= LoadCnt;
          end
        end
        StBusy: begin
          if (r_cnt == 4'd0) begin
            if (r_gnt_data) r_m_rdata <= mem_rdata;
            else            r_if_rdata <= mem_rdata;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign m_rdata   = r_m_rdata;

`ifdef MEMARB_PERF_EN
  logic [31:0] r_perf_ifetch;
  logic [31:0] r_perf_dacc;
  logic [31:0] r_perf_confl;
  logic        w_confl;

  assign w_confl = (r_state == StIdle) & if_req & m_req;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_perf_ifetch <= '0;
      r_perf_dacc   <= '0;
      r_perf_confl  <= '0;
    end else begin
      if (if_ack && (r_perf_ifetch != 32'hFFFF_FFFF)) r_perf_ifetch <= r_perf_ifetch + 32'd1;
      if (m_ack && (r_perf_dacc != 32'hFFFF_FFFF))    r_perf_dacc   <= r_perf_dacc + 32'd1;
      if (w_confl && (r_perf_confl != 32'hFFFF_FFFF)) r_perf_confl  <= r_perf_confl + 32'd1;
    end
  end

  assign perf_ifetch = r_perf_ifetch;
  assign perf_dacc   = r_perf_dacc;
  assign perf_confl  = r_perf_confl;
`endif

endmodule

// File: tb/tb_pipemem_arb.sv
// Scoreboard bench for pipemem_arb: directed stimulus pushes expected acks, a
// negedge monitor pops and compares. A second instance runs with WAIT_CYCLES=1.
module tb_pipemem_arb;

  typedef struct {
    bit          is_data;
    bit          chk;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        clrn;
  logic        if_req, m_req, m_we;
  logic [31:0] if_addr, m_addr, m_wdata;
  logic [31:0] if_rdata, m_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ack, m_ack, mem_en, mem_we;

  logic        w1_m_req;
  logic [31:0] w1_m_addr, w1_if_rdata, w1_m_rdata, w1_mem_addr, w1_mem_wdata, w1_mem_rdata;
  logic        w1_if_ack, w1_m_ack, w1_mem_en, w1_mem_we;

`ifdef MEMARB_PERF_EN
  logic [31:0] perf_ifetch, perf_dacc, perf_confl;
  logic [31:0] w1_perf_ifetch, w1_perf_dacc, w1_perf_confl;
`endif

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errs   = 0;
  int   cyc      = 0;

  // One-entry store memory on top of fixed read contents.
  logic        st_valid = 1'b0;
  logic [31:0] st_addr  = 32'h0;
  logic [31:0] st_data  = 32'h0;

  assign mem_rdata = (st_valid && st_addr == mem_addr) ? st_data :
                     (mem_addr == 32'h40) ? 32'h8C01_0004 : (32'hC0DE_0000 | mem_addr);
  assign w1_mem_rdata = w1_mem_addr ^ 32'hA5A5_0000;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en && mem_we) begin
      st_valid <= 1'b1;
      st_addr  <= mem_addr;
      st_data  <= mem_wdata;
    end
  end

  pipemem_arb #(.AW(32), .DW(32), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .clrn(clrn),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef MEMARB_PERF_EN
    , .perf_ifetch(perf_ifetch), .perf_dacc(perf_dacc), .perf_confl(perf_confl)
`endif
  );

  pipemem_arb #(.AW(32), .DW(32), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .clrn(clrn),
    .if_req(1'b0), .if_addr(32'h0), .if_rdata(w1_if_rdata), .if_ack(w1_if_ack),
    .m_req(w1_m_req), .m_we(1'b0), .m_addr(w1_m_addr), .m_wdata(32'h0),
    .m_rdata(w1_m_rdata), .m_ack(w1_m_ack),
    .mem_en(w1_mem_en), .mem_we(w1_mem_we), .mem_addr(w1_mem_addr),
    .mem_wdata(w1_mem_wdata), .mem_rdata(w1_mem_rdata)
`ifdef MEMARB_PERF_EN
    , .perf_ifetch(w1_perf_ifetch), .perf_dacc(w1_perf_dacc), .perf_confl(w1_perf_confl)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input string name);
    int n = 0;
    while (!(if_ack || m_ack) && n < 20) begin
      step();
      n++;
    end
    check(name, 32'(n < 20), 32'd1);
  endtask

  // Monitor: pops the scoreboard on every ack, independent of stimulus.
  always @(negedge clk) begin
    if (clrn) begin
      if (if_ack && m_ack) begin
        n_checks++;
        n_errs++;
        $display("FAIL dual_ack: got if_ack=1 m_ack=1 expected one ack");
      end else if (if_ack || m_ack) begin
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
          n_errs++;
          $display("FAIL unexpected_ack: got ack (m_ack=%0b) expected none", m_ack);
        end else begin
          e = sb.pop_front();
          if (e.is_data != m_ack) begin
            n_errs++;
            $display("FAIL ack_port: got m_ack=%0b expected %0b", m_ack, e.is_data);
          end else if (e.chk && ((m_ack ? m_rdata : if_rdata) !== e.rdata)) begin
            n_errs++;
            $display("FAIL ack_rdata: got %h expected %h", m_ack ? m_rdata : if_rdata, e.rdata);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t_prev, cnt;
    clrn = 1'b0; if_req = 1'b0; m_req = 1'b0; m_we = 1'b0;
    if_addr = 32'h0; m_addr = 32'h0; m_wdata = 32'h0;
    w1_m_req = 1'b0; w1_m_addr = 32'h0;
    step(); step();
    check("rst_mem_en", {31'b0, mem_en}, 32'd0);
    check("rst_acks", {30'b0, if_ack, m_ack}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    clrn = 1'b1;
    step();

    // Lone fetch
    if_req = 1'b1; if_addr = 32'h40;
    sb.push_back('{1'b0, 1'b1, 32'h8C01_0004});
    step();
    check("fetch_en_t1", {31'b0, mem_en}, 32'd1);
    check("fetch_addr_t1", mem_addr, 32'h40);
    step();
    check("fetch_en_t2", {31'b0, mem_en}, 32'd1);
    step();
    check("fetch_ack_t3", {31'b0, if_ack}, 32'd1);
    check("fetch_rdata", if_rdata, 32'h8C01_0004);
    check("fetch_en_done", {31'b0, mem_en}, 32'd0);
    if_req = 1'b0;
    step();

    // Store then load back
    m_req = 1'b1; m_we = 1'b1; m_addr = 32'h100; m_wdata = 32'hDEAD_BEEF;
    sb.push_back('{1'b1, 1'b0, 32'h0});
    step();
    check("st_we_t1", {30'b0, mem_en, mem_we}, 32'd3);
    check("st_wdata", mem_wdata, 32'hDEAD_BEEF);
    step();
    check("st_we_t2", {30'b0, mem_en, mem_we}, 32'd3);
    step();
    check("st_ack_t3", {31'b0, m_ack}, 32'd1);
    check("st_we_done", {31'b0, mem_we}, 32'd0);
    m_req = 1'b0; m_we = 1'b0;
    step();
    m_req = 1'b1;
    sb.push_back('{1'b1, 1'b1, 32'hDEAD_BEEF});
    wait_ack("ld_ack");
    m_req = 1'b0;
    step();

    // Reset in BUSY: outputs drop at once, no ack afterwards
    m_req = 1'b1;
    step();
    check("busy_before_rst", {31'b0, mem_en}, 32'd1);
    #3 clrn = 1'b0;
    #1;
    check("rst_async_en", {30'b0, mem_en, mem_we}, 32'd0);
    check("rst_async_rdata", if_rdata | m_rdata, 32'd0);
    m_req = 1'b0;
    step();
    clrn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      cnt += int'(mem_en) + int'(m_ack) + int'(if_ack);
    end
    check("post_rst_idle", cnt, 0);

    // Flush: fetch dropped while BUSY still acks exactly once
    if_req = 1'b1; if_addr = 32'h40;
    sb.push_back('{1'b0, 1'b1, 32'h8C01_0004});
    step();
    if_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      cnt += int'(if_ack);
    end
    check("flush_one_ack", cnt, 1);

    // Contention from reset: last_gnt resets to DATA, so IF wins first
    clrn = 1'b0;
    if_req = 1'b1; if_addr = 32'h40; m_req = 1'b1; m_we = 1'b0; m_addr = 32'h100;
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{1'b0, 1'b1, 32'h8C01_0004});
      sb.push_back('{1'b1, 1'b1, 32'hDEAD_BEEF});
    end
    step();
    clrn = 1'b1;
    t_prev = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      wait_ack("cont_ack");
      if (k > 0) check("cont_period", cyc - t_prev, 4);
      t_prev = cyc;
    end
    if_req = 1'b0; m_req = 1'b0;
    step(); step();
    check("sb_drained", sb.size(), 0);
`ifdef MEMARB_PERF_EN
    check("perf_ifetch", perf_ifetch, 32'd4);
    check("perf_dacc", perf_dacc, 32'd4);
    check("perf_confl", perf_confl, 32'd8);
`endif

    // WAIT_CYCLES=1 lone load: ack at t+2
    w1_m_req = 1'b1; w1_m_addr = 32'h10;
    step();
    check("w1_en_t1", {31'b0, w1_mem_en}, 32'd1);
    step();
    check("w1_ack_t2", {31'b0, w1_m_ack}, 32'd1);
    check("w1_rdata", w1_m_rdata, 32'hA5A5_0010);
    check("w1_en_done", {31'b0, w1_mem_en}, 32'd0);
    w1_m_req = 1'b0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
